// File: rtl/bsg_cam_lookup_fill_pkg.sv
// Shared types for the CAM lookup/fill controller.
package bsg_cam_lookup_fill_pkg;

    localparam int unsigned state_width_lp = 3;

    typedef enum logic [state_width_lp-1:0] {
        eIDLE      = 3'd0,
        eLOOKUP    = 3'd1,
        eFILL_REQ  = 3'd2,
        eFILL_RESP = 3'd3,
        eRESP      = 3'd4
    } bsg_cam_lookup_fill_state_e;

endpackage

// File: rtl/bsg_counter_sat_en.sv
// Up-counter that sticks at all-ones instead of wrapping.
module bsg_counter_sat_en #(
    parameter int unsigned width_p = 16
) (
    input  logic               clk_i,
    input  logic               reset_i,
    input  logic               en_i,
    output logic [width_p-1:0] count_o
);

    logic [width_p-1:0] count_q, count_d;

    always_comb begin
        count_d = count_q;
        if (en_i && (count_q != '1)) begin
            count_d = count_q + width_p'(1);
        end
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count_o = count_q;

endmodule

// File: rtl/bsg_dff_en.sv
// Load-enabled register, synchronously cleared to zero on reset.
module bsg_dff_en #(
    parameter int unsigned width_p = 1
) (
    input  logic               clk_i,
    input  logic               reset_i,
    input  logic               en_i,
    input  logic [width_p-1:0] data_i,
    output logic [width_p-1:0] data_o
);

    logic [width_p-1:0] data_q, data_d;

    always_comb begin
        data_d = data_q;
        if (en_i) begin
            data_d = data_i;
        end
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            data_q <= '0;
        end else begin
            data_q <= data_d;
        end
    end

    assign data_o = data_q;

endmodule

// File: rtl/bsg_dff_reset.sv
// Plain register with synchronous active-high reset to a fixed value.
module bsg_dff_reset #(
    parameter int unsigned         width_p     = 1,
    parameter logic [width_p-1:0]  reset_val_p = '0
) (
    input  logic               clk_i,
    input  logic               reset_i,
    input  logic [width_p-1:0] data_i,
    output logic [width_p-1:0] data_o
);

    logic [width_p-1:0] data_q;

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            data_q <= reset_val_p;
        end else begin
            data_q <= data_i;
        end
    end

    assign data_o = data_q;

endmodule

// File: rtl/bsg_cam_lookup_fill.sv
// Blocking lookup/fill front end for bsg_cam_1r1w_sync: reads the CAM, fills misses from a
// backing store, sequences nukes and counts hits/misses.
module bsg_cam_lookup_fill
    import bsg_cam_lookup_fill_pkg::*;
#(
    parameter int unsigned tag_width_p  = 8,
    parameter int unsigned data_width_p = 16,
    parameter int unsigned ctr_width_p  = 16
) (
    input  logic                    clk_i,
    input  logic                    reset_i,

    input  logic                    v_i,
    input  logic [tag_width_p-1:0]  tag_i,
    output logic                    ready_o,

    output logic                    v_o,
    output logic [data_width_p-1:0] data_o,
    input  logic                    yumi_i,

    input  logic                    flush_i,

    output logic                    fill_req_v_o,
    output logic [tag_width_p-1:0]  fill_req_tag_o,
    input  logic                    fill_req_ready_i,
    input  logic                    fill_resp_v_i,
    input  logic [data_width_p-1:0] fill_resp_data_i,
    output logic                    fill_resp_yumi_o,

    output logic                    cam_w_v_o,
    output logic                    cam_w_nuke_o,
    output logic [tag_width_p-1:0]  cam_w_tag_o,
    output logic [data_width_p-1:0] cam_w_data_o,
    output logic                    cam_r_v_o,
    output logic [tag_width_p-1:0]  cam_r_tag_o,
    input  logic                    cam_r_v_i,
    input  logic [data_width_p-1:0] cam_r_data_i,

    output logic [ctr_width_p-1:0]  hit_count_o,
    output logic [ctr_width_p-1:0]  miss_count_o
);

    bsg_cam_lookup_fill_state_e state_q, state_d;
    logic [state_width_lp-1:0]  state_raw;

    logic [tag_width_p-1:0]  tag_q;
    logic                    tag_en;
    logic [data_width_p-1:0] data_q, data_d;
    logic                    data_en;
    logic                    flush_pend_q, flush_pend_d;
    logic                    flush_req;
    logic                    hit_inc, miss_inc;

    bsg_dff_reset #(
        .width_p    (state_width_lp),
        .reset_val_p(state_width_lp'(eIDLE))
    ) state_reg (
        .clk_i  (clk_i),
        .reset_i(reset_i),
        .data_i (state_d),
        .data_o (state_raw)
    );

    assign state_q = bsg_cam_lookup_fill_state_e'(state_raw);

    bsg_dff_reset #(
        .width_p    (1),
        .reset_val_p(1'b0)
    ) flush_pend_reg (
        .clk_i  (clk_i),
        .reset_i(reset_i),
        .data_i (flush_pend_d),
        .data_o (flush_pend_q)
    );

    bsg_dff_en #(
        .width_p(tag_width_p)
    ) tag_reg (
        .clk_i  (clk_i),
        .reset_i(reset_i),
        .en_i   (tag_en),
        .data_i (tag_i),
        .data_o (tag_q)
    );

    bsg_dff_en #(
        .width_p(data_width_p)
    ) data_reg (
        .clk_i  (clk_i),
        .reset_i(reset_i),
        .en_i   (data_en),
        .data_i (data_d),
        .data_o (data_q)
    );

    bsg_counter_sat_en #(
        .width_p(ctr_width_p)
    ) hit_ctr (
        .clk_i  (clk_i),
        .reset_i(reset_i),
        .en_i   (hit_inc),
        .count_o(hit_count_o)
    );

    bsg_counter_sat_en #(
        .width_p(ctr_width_p)
    ) miss_ctr (
        .clk_i  (clk_i),
        .reset_i(reset_i),
        .en_i   (miss_inc),
        .count_o(miss_count_o)
    );

    assign flush_req = flush_i | flush_pend_q;

    always_comb begin
        state_d          = state_q;
        flush_pend_d     = flush_pend_q;
        tag_en           = 1'b0;
        data_en          = 1'b0;
        data_d           = cam_r_data_i;
        hit_inc          = 1'b0;
        miss_inc         = 1'b0;
        ready_o          = 1'b0;
        v_o              = 1'b0;
        fill_req_v_o     = 1'b0;
        fill_resp_yumi_o = 1'b0;
        cam_w_v_o        = 1'b0;
        cam_w_nuke_o     = 1'b0;
        cam_r_v_o        = 1'b0;

        unique case (state_q)
            eIDLE: begin
                ready_o = ~flush_i & ~flush_pend_q;
                // A nuke takes the CAM write port and blocks the read for that cycle.
                if (flush_req) begin
                    cam_w_v_o    = 1'b1;
                    cam_w_nuke_o = 1'b1;
                    flush_pend_d = 1'b0;
                end else if (v_i) begin
                    cam_r_v_o = 1'b1;
                    tag_en    = 1'b1;
                    state_d   = eLOOKUP;
                end
            end
            eLOOKUP: begin
                if (cam_r_v_i) begin
                    data_en = 1'b1;
                    hit_inc = 1'b1;
                    state_d = eRESP;
                end else begin
                    miss_inc = 1'b1;
                    state_d  = eFILL_REQ;
                end
            end
            eFILL_REQ: begin
                fill_req_v_o = 1'b1;
                if (fill_req_ready_i) begin
                    state_d = eFILL_RESP;
                end
            end
            eFILL_RESP: begin
                fill_resp_yumi_o = fill_resp_v_i;
                if (fill_resp_v_i) begin
                    cam_w_v_o = 1'b1;
                    data_d    = fill_resp_data_i;
                    data_en   = 1'b1;
                    state_d   = eRESP;
                end
            end
            eRESP: begin
                v_o = 1'b1;
                if (yumi_i) begin
                    state_d = eIDLE;
                end
            end
            default: begin
                state_d = eIDLE;
            end
        endcase

        // Flushes seen while busy are replayed on the next idle cycle.
        if ((state_q != eIDLE) && flush_i) begin
            flush_pend_d = 1'b1;
        end

        if (reset_i) begin
            ready_o          = 1'b0;
            v_o              = 1'b0;
            fill_req_v_o     = 1'b0;
            fill_resp_yumi_o = 1'b0;
            cam_w_v_o        = 1'b0;
            cam_w_nuke_o     = 1'b0;
            cam_r_v_o        = 1'b0;
        end
    end

    assign data_o         = data_q;
    assign fill_req_tag_o = tag_q;
    assign cam_w_tag_o    = tag_q;
    assign cam_w_data_o   = fill_resp_data_i;
    assign cam_r_tag_o    = tag_i;

endmodule

// File: tb/tb_bsg_cam_lookup_fill.sv
// Bench for bsg_cam_lookup_fill with a 4-entry FIFO-replacement CAM and a 2-cycle backing store.
module tb_bsg_cam_lookup_fill;

    localparam int unsigned TW = 8;
    localparam int unsigned DW = 16;
    localparam int unsigned CW = 2;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          reset_i, v_i, yumi_i, flush_i, fill_req_ready_i;
    logic [TW-1:0] tag_i;
    logic          ready_o, v_o, fill_req_v_o, fill_resp_v_i, fill_resp_yumi_o;
    logic [DW-1:0] data_o, fill_resp_data_i, cam_w_data_o, cam_r_data_i;
    logic [TW-1:0] fill_req_tag_o, cam_w_tag_o, cam_r_tag_o;
    logic          cam_w_v_o, cam_w_nuke_o, cam_r_v_o, cam_r_v_i;
    logic [CW-1:0] hit_count_o, miss_count_o;

    bsg_cam_lookup_fill #(
        .tag_width_p (TW),
        .data_width_p(DW),
        .ctr_width_p (CW)
    ) dut (
        .clk_i           (clk),
        .reset_i         (reset_i),
        .v_i             (v_i),
        .tag_i           (tag_i),
        .ready_o         (ready_o),
        .v_o             (v_o),
        .data_o          (data_o),
        .yumi_i          (yumi_i),
        .flush_i         (flush_i),
        .fill_req_v_o    (fill_req_v_o),
        .fill_req_tag_o  (fill_req_tag_o),
        .fill_req_ready_i(fill_req_ready_i),
        .fill_resp_v_i   (fill_resp_v_i),
        .fill_resp_data_i(fill_resp_data_i),
        .fill_resp_yumi_o(fill_resp_yumi_o),
        .cam_w_v_o       (cam_w_v_o),
        .cam_w_nuke_o    (cam_w_nuke_o),
        .cam_w_tag_o     (cam_w_tag_o),
        .cam_w_data_o    (cam_w_data_o),
        .cam_r_v_o       (cam_r_v_o),
        .cam_r_tag_o     (cam_r_tag_o),
        .cam_r_v_i       (cam_r_v_i),
        .cam_r_data_i    (cam_r_data_i),
        .hit_count_o     (hit_count_o),
        .miss_count_o    (miss_count_o)
    );

    // CAM stand-in: synchronous read, round-robin write slot, nuke clears everything.
    bit [TW-1:0] cm_tag [4];
    bit [DW-1:0] cm_data[4];
    bit          cm_v   [4];
    int          cm_ptr;

    always @(posedge clk) begin
        cam_r_v_i <= 1'b0;
        if (cam_r_v_o) begin
            for (int i = 0; i < 4; i++) begin
                if (cm_v[i] && cm_tag[i] == cam_r_tag_o) begin
                    cam_r_v_i    <= 1'b1;
                    cam_r_data_i <= cm_data[i];
                end
            end
        end
        if (cam_w_v_o) begin
            if (cam_w_nuke_o) begin
                for (int i = 0; i < 4; i++) cm_v[i] <= 1'b0;
                cm_ptr <= 0;
            end else begin
                cm_v[cm_ptr]    <= 1'b1;
                cm_tag[cm_ptr]  <= cam_w_tag_o;
                cm_data[cm_ptr] <= cam_w_data_o;
                cm_ptr          <= (cm_ptr + 1) % 4;
            end
        end
    end

    // Backing store: data valid two cycles after the request handshake, held until taken.
    bit          bs_busy, bs_drop;
    int          bs_delay;
    bit [TW-1:0] bs_tag;

    always @(posedge clk) begin
        if (bs_drop) begin
            bs_busy <= 1'b0;
        end else if (bs_busy) begin
            if (bs_delay > 0) bs_delay <= bs_delay - 1;
            else if (fill_resp_yumi_o) bs_busy <= 1'b0;
        end else if (fill_req_v_o && fill_req_ready_i) begin
            bs_busy  <= 1'b1;
            bs_delay <= 1;
            bs_tag   <= fill_req_tag_o;
        end
    end

    assign fill_resp_v_i    = bs_busy && (bs_delay == 0);
    assign fill_resp_data_i = {bs_tag, ~bs_tag};

    int checks, errors;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (fill_resp_yumi_o) chk("yumi_needs_fill_v", 32'(fill_resp_v_i), 32'd1);
        if (cam_r_v_o) chk("no_read_with_write", 32'(cam_w_v_o), 32'd0);
    end

    // Reference: set of tags the CAM should hold (oldest first) and ideal counts.
    logic [TW-1:0] ref_q[$];
    int            ref_hit, ref_miss;

    function automatic bit in_ref(input logic [TW-1:0] t);
        foreach (ref_q[i]) if (ref_q[i] == t) return 1'b1;
        return 1'b0;
    endfunction

    function automatic int sat(input int x);
        int m;
        m = (1 << CW) - 1;
        return (x > m) ? m : x;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset_i = 1'b1; v_i = 1'b0; yumi_i = 1'b0; flush_i = 1'b0; fill_req_ready_i = 1'b0;
        repeat (2) tick();
        reset_i  = 1'b0;
        ref_hit  = 0;
        ref_miss = 0;
        @(negedge clk);
        chk("rst_ready", 32'(ready_o), 32'd1);
        chk("rst_v_o", 32'(v_o), 32'd0);
        chk("rst_fill_req", 32'(fill_req_v_o), 32'd0);
        chk("rst_cam_w", 32'(cam_w_v_o), 32'd0);
        chk("rst_hits", 32'(hit_count_o), 32'd0);
        chk("rst_misses", 32'(miss_count_o), 32'd0);
        tick();
    endtask

    task automatic pulse_flush();
        flush_i = 1'b1;
        @(negedge clk);
        chk("nuke_issued", 32'(cam_w_v_o && cam_w_nuke_o), 32'd1);
        chk("nuke_ready_low", 32'(ready_o), 32'd0);
        tick();
        flush_i = 1'b0;
        @(negedge clk);
        chk("nuke_one_cycle", 32'(cam_w_v_o), 32'd0);
        chk("ready_after_nuke", 32'(ready_o), 32'd1);
        tick();
        ref_q.delete();
    endtask

    task automatic lookup(input logic [TW-1:0] t, input bit exp_hit, input logic [DW-1:0] exp_d,
                          input int yumi_wait, input int req_stall, input bit flush_in_fill);
        int            cyc, lat, w_lat, req_cnt;
        bit            acc, got_v, saw_req, saw_w;
        logic [TW-1:0] rtag, wtag;
        logic [DW-1:0] wdata;
        acc = 0; cyc = 0;
        v_i = 1'b1; tag_i = t;
        while (!acc && cyc < 20) begin
            @(negedge clk);
            acc = ready_o;
            tick();
            cyc++;
        end
        v_i = 1'b0; tag_i = TW'($urandom);
        if (!acc) begin
            chk("accept_timeout", 32'd0, 32'd1);
            return;
        end
        lat = 1; w_lat = 0; req_cnt = 0; got_v = 0; saw_req = 0; saw_w = 0;
        rtag = '0; wtag = '0; wdata = '0;
        while (!got_v && lat < 40) begin
            @(negedge clk);
            if (v_o) begin
                got_v = 1'b1;
            end else begin
                if (fill_req_v_o) begin
                    if (req_cnt == 0) begin
                        rtag = fill_req_tag_o;
                        if (flush_in_fill) flush_i = 1'b1;
                    end else begin
                        chk("req_tag_stable", 32'(fill_req_tag_o), 32'(rtag));
                    end
                    saw_req = 1'b1;
                    fill_req_ready_i = (req_cnt >= req_stall);
                    req_cnt++;
                end
                if (cam_w_v_o && !cam_w_nuke_o) begin
                    saw_w = 1'b1; wtag = cam_w_tag_o; wdata = cam_w_data_o; w_lat = lat;
                end
                tick();
                fill_req_ready_i = 1'b0;
                flush_i = 1'b0;
                lat++;
            end
        end
        if (!got_v) begin
            chk("resp_timeout", 32'd0, 32'd1);
            return;
        end
        chk("resp_data", 32'(data_o), 32'(exp_d));
        chk("hit_path", 32'(!saw_req), 32'(exp_hit));
        if (exp_hit) begin
            chk("hit_latency", 32'(lat), 32'd2);
        end else begin
            chk("fill_req_tag", 32'(rtag), 32'(t));
            chk("fill_req_cycles", 32'(req_cnt), 32'(req_stall + 1));
            chk("fill_write_seen", 32'(saw_w), 32'd1);
            chk("fill_write_tag", 32'(wtag), 32'(t));
            chk("fill_write_data", 32'(wdata), 32'(exp_d));
            chk("miss_latency", 32'(lat), 32'(w_lat + 1));
        end
        for (int k = 0; k < yumi_wait; k++) begin
            tick();
            @(negedge clk);
            chk("bp_v_o", 32'(v_o), 32'd1);
            chk("bp_data", 32'(data_o), 32'(exp_d));
            chk("bp_ready", 32'(ready_o), 32'd0);
        end
        yumi_i = 1'b1;
        tick();
        yumi_i = 1'b0;
        if (exp_hit) begin
            ref_hit++;
        end else begin
            ref_miss++;
            ref_q.push_back(t);
            if (ref_q.size() > 4) void'(ref_q.pop_front());
        end
        @(negedge clk);
        chk("hit_count", 32'(hit_count_o), 32'(sat(ref_hit)));
        chk("miss_count", 32'(miss_count_o), 32'(sat(ref_miss)));
        if (flush_in_fill) begin
            chk("pending_nuke", 32'(cam_w_v_o && cam_w_nuke_o), 32'd1);
            chk("pending_ready_low", 32'(ready_o), 32'd0);
            ref_q.delete();
            tick();
        end
        tick();
    endtask

    typedef struct {
        logic [TW-1:0] tag;
        bit            hit;
        logic [DW-1:0] data;
        int            hits;
        int            misses;
        int            yumi_wait;
        int            req_stall;
    } vec_t;

    vec_t          tbl[8];
    logic [TW-1:0] pool[6] = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66};
    logic [TW-1:0] rt;
    bit            rh, rf;

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        checks = 0; errors = 0; bs_drop = 1'b0; tag_i = '0;
        tbl[0] = '{8'h11, 1'b0, 16'h11ee, 0, 1, 5, 3};
        tbl[1] = '{8'h11, 1'b1, 16'h11ee, 1, 1, 5, 0};
        tbl[2] = '{8'h22, 1'b0, 16'h22dd, 1, 2, 0, 0};
        tbl[3] = '{8'h22, 1'b1, 16'h22dd, 2, 2, 1, 0};
        tbl[4] = '{8'h00, 1'b0, 16'h00ff, 2, 3, 0, 1};
        tbl[5] = '{8'h33, 1'b0, 16'h33cc, 2, 3, 0, 0};
        tbl[6] = '{8'h11, 1'b1, 16'h11ee, 3, 3, 2, 0};
        tbl[7] = '{8'h44, 1'b0, 16'h44bb, 3, 3, 0, 2};

        do_reset();
        for (int i = 0; i < 8; i++) begin
            lookup(tbl[i].tag, tbl[i].hit, tbl[i].data, tbl[i].yumi_wait, tbl[i].req_stall, 1'b0);
            @(negedge clk);
            chk("tbl_hits", 32'(hit_count_o), 32'(tbl[i].hits));
            chk("tbl_misses", 32'(miss_count_o), 32'(tbl[i].misses));
            tick();
        end

        // Flush while idle drops previously filled tags.
        do_reset();
        pulse_flush();
        lookup(8'h00, 1'b0, 16'h00ff, 0, 0, 1'b0);
        lookup(8'h22, 1'b0, 16'h22dd, 0, 0, 1'b0);
        pulse_flush();
        lookup(8'h00, 1'b0, 16'h00ff, 0, 0, 1'b0);
        @(negedge clk);
        chk("flush_idle_misses", 32'(miss_count_o), 32'd3);
        tick();

        // Flush during a fill: response still returns, entry gone afterwards.
        do_reset();
        lookup(8'h33, 1'b0, 16'h33cc, 0, 1, 1'b1);
        lookup(8'h33, 1'b0, 16'h33cc, 0, 0, 1'b0);
        @(negedge clk);
        chk("flush_fill_misses", 32'(miss_count_o), 32'd2);
        tick();

        // Reset while waiting for fill data.
        v_i = 1'b1; tag_i = 8'h55; fill_req_ready_i = 1'b1;
        tick();
        v_i = 1'b0;
        tick();
        tick();
        fill_req_ready_i = 1'b0;
        reset_i = 1'b1;
        @(negedge clk);
        chk("midrst_yumi", 32'(fill_resp_yumi_o), 32'd0);
        chk("midrst_cam_w", 32'(cam_w_v_o), 32'd0);
        chk("midrst_v_o", 32'(v_o), 32'd0);
        tick();
        tick();
        reset_i = 1'b0;
        ref_hit = 0; ref_miss = 0;
        @(negedge clk);
        if (fill_resp_v_i) chk("stale_fill_not_taken", 32'(fill_resp_yumi_o), 32'd0);
        chk("postrst_ready", 32'(ready_o), 32'd1);
        chk("postrst_fill_req", 32'(fill_req_v_o), 32'd0);
        chk("postrst_cam_w", 32'(cam_w_v_o), 32'd0);
        chk("postrst_misses", 32'(miss_count_o), 32'd0);
        chk("postrst_hits", 32'(hit_count_o), 32'd0);
        tick();
        bs_drop = 1'b1;
        tick();
        bs_drop = 1'b0;
        lookup(8'h55, 1'b0, 16'h55aa, 0, 0, 1'b0);
        lookup(8'h55, 1'b1, 16'h55aa, 0, 0, 1'b0);

        // Random traffic against the reference set.
        for (int n = 0; n < 60; n++) begin
            rt = pool[$urandom_range(0, 5)];
            if ($urandom_range(0, 7) == 0) pulse_flush();
            rh = in_ref(rt);
            rf = !rh && ($urandom_range(0, 5) == 0);
            lookup(rt, rh, {rt, ~rt}, $urandom_range(0, 3), $urandom_range(0, 2), rf);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
